// File: rtl/spike_queue_arbiter_pkg.sv
// Shared types and constants for the spike queue arbiter.
// Data width, pop FSM encoding and stats counter width.
package spike_queue_arbiter_pkg;
  localparam int DATA_W = 8;
  localparam int STAT_W = 16;
  typedef enum logic {IDLE, RD} state_t;
endpackage

// File: rtl/spike_queue_arbiter_if.sv
// Producer and consumer handshake bundle for the arbiter.
// The slave side is the arbiter; the master side drives producers/consumer.
interface spike_queue_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import spike_queue_arbiter_pkg::*;
  logic [NUM_REQ-1:0]        req_valid;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      pop_req;
  logic                      pop_valid;
  logic [DATA_W-1:0]         pop_data;

  modport slave (
    input  req_valid, req_data, pop_req,
    output req_ready, pop_valid, pop_data
  );
  modport master (
    output req_valid, req_data, pop_req,
    input  req_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant of the first request
// found when searching upward from ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i >= int'(ptr)) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i < int'(ptr)) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spike_queue_arbiter.sv
// N producers share one byte queue; single consumer pops via IDLE/RD FSM.
// Define QARB_STATS_EN to add saturating insert/stall counters.
module spike_queue_arbiter
  import spike_queue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_SIZE = 1024,
  localparam int OCC_W = $clog2(MAX_SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst,
  spike_queue_arbiter_if.slave bus,
  output logic              q_insert,
  output logic              q_read,
  output logic [DATA_W-1:0] q_data,
  input  logic [DATA_W-1:0] q_rdata,
  output logic [OCC_W-1:0]  occupancy,
  output logic              full,
  output logic              empty
`ifdef QARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_inserts,
  output logic [STAT_W-1:0] stat_stalls
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gidx;
  logic [OCC_W-1:0]   occ_q;
  logic [NUM_REQ-1:0] grant;
  logic               rd;
  logic               pop_valid_q;
  logic [DATA_W-1:0]  pop_data_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign occupancy = occ_q;
  assign full      = occ_q == OCC_W'(MAX_SIZE);
  assign empty     = occ_q == '0;

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.pop_req && !empty) begin
          rd      = 1'b1;
          state_d = RD;
        end
      end
      RD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read strobe owns the queue port that cycle, so inserts back off.
  assign q_read        = rd && !rst;
  assign bus.req_ready = grant & {NUM_REQ{!full && !rd && !rst}};
  assign q_insert      = |(bus.req_valid & bus.req_ready);
  assign bus.pop_valid = pop_valid_q;
  assign bus.pop_data  = pop_data_q;

  always_comb begin
    q_data = '0;
    gidx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ready[i]) begin
        q_data = bus.req_data[DATA_W*i +: DATA_W];
        gidx   = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr      <= '0;
      occ_q       <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pop_valid_q <= state_q == RD;
      if (state_q == RD) pop_data_q <= q_rdata;
      if (q_insert) begin
        rr_ptr <= (gidx == PTR_W'(NUM_REQ - 1))
                  ? '0 : gidx + PTR_W'(1);
      end
      if (q_insert)    occ_q <= occ_q + OCC_W'(1);
      else if (q_read) occ_q <= occ_q - OCC_W'(1);
    end
  end

`ifdef QARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_inserts <= '0;
      stat_stalls  <= '0;
    end else begin
      if (q_insert && stat_inserts != '1)
        stat_inserts <= stat_inserts + STAT_W'(1);
      if (|bus.req_valid && !q_insert && stat_stalls != '1)
        stat_stalls <= stat_stalls + STAT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_spike_queue_arbiter.sv
// Bench for spike_queue_arbiter: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_spike_queue_arbiter;
  import spike_queue_arbiter_pkg::*;
  localparam int N   = 4;
  localparam int MAX = 1024;
  localparam int OW  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_queue_arbiter_if #(.NUM_REQ(N)) bus ();
  logic          q_insert, q_read;
  logic [7:0]    q_data;
  logic [7:0]    q_rdata;
  logic [OW-1:0] occupancy;
  logic          full, empty;
`ifdef QARB_STATS_EN
  logic [15:0]   stat_inserts, stat_stalls;
`endif

  spike_queue_arbiter #(.NUM_REQ(N), .MAX_SIZE(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .q_insert  (q_insert),
    .q_read    (q_read),
    .q_data    (q_data),
    .q_rdata   (q_rdata),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
`ifdef QARB_STATS_EN
    ,
    .stat_inserts (stat_inserts),
    .stat_stalls  (stat_stalls)
`endif
  );

  // External queue storage driven by the DUT strobes
  logic [7:0] mem[$];
  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
      q_rdata <= 8'h00;
    end else begin
      if (q_insert) mem.push_back(q_data);
      if (q_read && mem.size() > 0) q_rdata <= mem.pop_front();
    end
  end

  int         n_chk = 0;
  int         n_err = 0;
  int         m_ptr, m_occ, exp_g, m_ins, m_stl;
  logic [7:0] mq[$];
  bit         m_rd, m_popv, exp_rd;
  logic [7:0] m_popd, m_pend;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    int i;
    @(negedge clk);
    exp_rd = !rst && !m_rd && bus.pop_req && m_occ > 0;
    exp_g = -1;
    if (!rst && !exp_rd && m_occ < MAX)
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (exp_g < 0 && bus.req_valid[i]) exp_g = i;
      end
    chk("req_ready", 32'(bus.req_ready), exp_g >= 0 ? (32'd1 << exp_g) : 0);
    chk("q_insert", 32'(q_insert), 32'(exp_g >= 0));
    chk("q_read", 32'(q_read), 32'(exp_rd));
    if (exp_g >= 0)
      chk("q_data", 32'(q_data), 32'(bus.req_data[8*exp_g +: 8]));
    chk("occupancy", 32'(occupancy), m_occ);
    chk("full", 32'(full), 32'(m_occ == MAX));
    chk("empty", 32'(empty), 32'(m_occ == 0));
    chk("pop_valid", 32'(bus.pop_valid), 32'(m_popv));
    chk("pop_data", 32'(bus.pop_data), 32'(m_popd));
`ifdef QARB_STATS_EN
    chk("stat_inserts", 32'(stat_inserts), m_ins);
    chk("stat_stalls", 32'(stat_stalls), m_stl);
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_occ = 0; mq.delete();
      m_rd = 0; m_popv = 0; m_popd = 0; m_pend = 0;
      m_ins = 0; m_stl = 0;
    end else begin
      m_popv = m_rd;
      if (m_rd) m_popd = m_pend;
      m_rd = exp_rd;
      if (exp_rd) begin
        m_pend = mq.pop_front();
        m_occ--;
      end
      if (exp_g >= 0) begin
        mq.push_back(bus.req_data[8*exp_g +: 8]);
        m_occ++;
        m_ptr = (exp_g + 1) % N;
        if (m_ins < 65535) m_ins++;
      end else if (bus.req_valid != 0 && m_stl < 65535) begin
        m_stl++;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.pop_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] pv[12] = '{4'b1010, 4'b0110, 4'b0000, 4'b1001, 4'b1111,
                         4'b0001, 4'b1100, 4'b0010, 4'b0000, 4'b0101,
                         4'b1000, 4'b0000};
  logic       pp[12] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1};

  initial begin
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h44332211;
    bus.pop_req   = 1'b0;
    rst = 1'b1;
    adv();
    settle();
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pop_data", 32'(bus.pop_data), 0);
    adv();
    rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      settle();
      chk("rr_seq", 32'(bus.req_ready), 32'd1 << (c % 4));
      adv();
    end
    bus.req_valid = '0;
    settle();
    chk("occ_after_8", 32'(occupancy), 8);
    adv();

    bus.req_valid = 4'hF;
    repeat (3) tick();
    bus.req_valid = 4'b0100;
    settle();
    chk("lone_req2", 32'(bus.req_ready), 4);
    adv();
    bus.req_valid = 4'hF;
    settle();
    chk("ptr_stays_3", 32'(bus.req_ready), 8);
    adv();

    for (int k = 0; k < 12; k++) begin
      bus.req_valid = pv[k];
      bus.req_data  = {8'(k), 8'(k + 16), 8'(k + 32), 8'(k + 48)};
      bus.pop_req   = pp[k];
      tick();
    end
    bus.req_valid = '0;
    bus.pop_req = 1'b1;
    repeat (40) tick();

    do_reset();
    bus.req_data = 32'h00005AA5;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    bus.pop_req = 1'b1;
    settle();
    chk("rd_cycle_read", 32'(q_read), 1);
    chk("rd_cycle_nogrant", 32'(bus.req_ready), 0);
    adv();
    bus.pop_req = 1'b0;
    settle();
    chk("rd_state_insert", 32'(bus.req_ready), 2);
    adv();
    bus.req_valid = '0;
    settle();
    chk("pop_valid_a5", 32'(bus.pop_valid), 1);
    chk("pop_data_a5", 32'(bus.pop_data), 32'hA5);
    adv();

    do_reset();
    bus.pop_req = 1'b1;
    repeat (5) begin
      settle();
      chk("empty_no_read", 32'(q_read), 0);
      adv();
    end
    bus.req_data = 32'h003C0000;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    settle();
    chk("read_after_insert", 32'(q_read), 1);
    adv();
    bus.pop_req = 1'b0;
    tick();
    settle();
    chk("pop_data_3c", 32'(bus.pop_data), 32'h3C);
    adv();

    do_reset();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    bus.pop_req = 1'b1;
    settle();
    chk("pre_abort_read", 32'(q_read), 1);
    adv();
    bus.pop_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'hF;
    settle();
    chk("abort_no_pop", 32'(bus.pop_valid), 0);
    chk("abort_occ", 32'(occupancy), 0);
    chk("abort_ptr0", 32'(bus.req_ready), 1);
    adv();

    do_reset();
    bus.req_data = 32'h44332211;
    bus.req_valid = 4'hF;
    repeat (MAX) tick();
    settle();
    chk("fill_full", 32'(full), 1);
    chk("fill_ready0", 32'(bus.req_ready), 0);
    chk("fill_occ", 32'(occupancy), MAX);
    adv();
    bus.pop_req = 1'b1;
    settle();
    chk("full_pop_read", 32'(q_read), 1);
    adv();
    bus.pop_req = 1'b0;
    settle();
    chk("resume_grant", 32'(q_insert), 1);
    adv();
    settle();
    chk("refill_occ", 32'(occupancy), MAX);
    adv();
    bus.req_valid = '0;
    bus.pop_req = 1'b1;
    repeat (8) tick();
    bus.pop_req = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
